mpmc10_wmask_sequencer: RTL and testbench
=========================================

# mpmc10_wmask_sequencer

Write-mask sequencer for the mpmc10 multi-port memory controller. Sits between the port arbiter and the DRAM write-data FIFO. At PRESET1 it captures the selected channel's write enable, byte selects, address and burst length. It places narrow client byte-selects into the correct lanes of the wide DRAM beat, then presents one registered mask per beat under a valid/ready handshake until the burst completes.

## Interface
Parameters:
- WID, 16: DRAM beat width in byte lanes; power of two, 4..64.
- SELW, 16: client byte-select width; power of two, ≤ WID.
- NCH, 8: number of client channels.
- BLW, 3: burst-length field width; bursts are 1..2^BLW beats.

Ports:
- clk  in  1  controller clock
- rst_n  in  1  asynchronous, active-low reset
- state  in  mpmc10_state_t  controller state
- ch  in  $clog2(NCH)  channel granted by arbiter; sampled only in PRESET1
- we  in  NCH  per-channel write enable
- sel  in  NCH×SELW  per-channel byte selects; packed [NCH-1:0][SELW-1:0]
- adr  in  NCH×32  per-channel byte address
- blen  in  NCH×BLW  per-channel burst length minus one
- beat_rdy  in  1  write-data path accepts current beat
- mask  out  WID  DRAM mask; 1 = byte NOT written
- mask_vld  out  1  mask valid for current beat
- last  out  1  current beat is final beat of burst
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after final beat accepted

## Operation
- Reset (rst_n low, any time, asynchronous): FSM to S_IDLE. Outputs: mask=0, mask_vld=0, last=0, busy=0, done=0. Beat counter=0.
- FSM states:
  - S_IDLE: when state==PRESET1, load channel ch and go to S_BEAT.
  - S_BEAT: issue beats. On the final beat handshake, go to S_DONE. If state==IDLE (controller abort), go to S_IDLE immediately with no done pulse.
  - S_DONE: one cycle, done=1, then S_IDLE.
- Load:
  - Lane offset off = adr[$clog2(WID)-1:$clog2(SELW)] × SELW. Offset is 0 when SELW==WID.
  - Write (we[ch]=1): mask = ~(zero-extend(sel[ch]) << off), WID bits. Bytes outside the placed field are masked.
  - Read (we[ch]=0): mask = 0, so all bytes are enabled.
  - The beat total is blen[ch]+1.
- Every beat of a burst carries the same mask.
- Handshake: a beat transfers when mask_vld && beat_rdy. mask, mask_vld and last are held stable until the transfer. The beat counter increments per transfer, and last = (count == blen_latched).
- PRESET1 while busy is ignored; no reload occurs.
- Channel inputs are not re-sampled after load. Changes to sel/adr/we mid-burst have no effect.

## Timing
- PRESET1 sampled at edge t: mask, mask_vld=1 and busy=1 are visible after edge t. First transfer is possible in cycle t+1.
- Single beat (blen=0): last=1 with the first mask_vld.
- With beat_rdy held high, a burst of N beats occupies N consecutive cycles. mask_vld falls and done=1 in the cycle after the final transfer. busy falls with done.
- beat_rdy low stalls indefinitely with outputs held.
- Abort: state==IDLE observed at an edge in S_BEAT clears mask_vld, busy and last after that edge. mask returns to 0.
- Earliest reload is the cycle after done (from S_IDLE).

## Structure
- mpmc10_pkg: add typedef enum mpmc10_wmask_state_t {S_IDLE, S_BEAT, S_DONE}. mpmc10_state_t (PRESET1, IDLE) already lives there.
- Sub-module mpmc10_lane_place: combinational SELW→WID shift and invert, parametrised WID/SELW, with a we input that forces the output to 0. It is instantiated once on the selected channel.
- All outputs are registered; no combinational path from beat_rdy to mask.

## Test plan
- Reset mid-burst: assert rst_n=0 during beat 2 of 4 -> all outputs 0 in the same cycle, no done; after release, PRESET1 loads cleanly.
- Narrow write, WID=16, SELW=4, ch=3, sel=4'b0110, adr=0x…08, blen=0 -> mask=16'hF9FF, last=1, single transfer, done one cycle later.
- Read burst, we=0, blen=7, beat_rdy=1 -> mask=0 for 8 consecutive transfers, last only on the 8th, done on the 9th cycle.
- Stall: write blen=3, toggle beat_rdy 1,0,0,1,1,0,1 -> exactly 4 transfers, mask stable through stalls, last asserted at the 4th.
- Abort and ignored reload: state→IDLE after the 2nd of 4 beats -> mask_vld=0, no done. Separately, PRESET1 with different ch during busy -> mask unchanged, burst completes with the original beat count.

Source files
------------

// File: rtl/mpmc10_pkg.sv
// Shared mpmc10 controller types: controller state encoding and the write-mask sequencer FSM states.
// The sequencer states are the only addition here; the controller states already exist.
package mpmc10_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRESET1,
    PRESET2,
    PRESET3,
    ACTIVATE,
    READ_DATA,
    WRITE_DATA,
    PRECHARGE
  } mpmc10_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_DONE
  } mpmc10_wmask_state_t;

endpackage

// File: rtl/mpmc10_lane_place.sv
// Places SELW client byte selects into their lane group of a WID-byte beat and inverts them into a mask.
// Combinational, no latency or backpressure; a read (we=0) enables every byte.
module mpmc10_lane_place #(
  parameter int WID  = 16,
  parameter int SELW = 16
) (
  input  logic                   we,
  input  logic [SELW-1:0]        sel,
  input  logic [$clog2(WID)-1:0] lane_adr,
  output logic [WID-1:0]         mask
);

  localparam int LW = $clog2(WID);

  logic [LW-1:0]  off;
  logic [WID-1:0] placed;

  // Clearing the low address bits gives the lane-group start; it is 0 when SELW==WID.
  assign off    = lane_adr & ~LW'(SELW - 1);
  assign placed = WID'(sel) << off;
  assign mask   = we ? ~placed : '0;

endmodule

// File: rtl/mpmc10_wmask_sequencer.sv
// Latches the granted channel at PRESET1 and presents one registered mask per beat until the burst ends.
// Mask visible the cycle after PRESET1; beats held indefinitely while beat_rdy is low.
module mpmc10_wmask_sequencer
  import mpmc10_pkg::*;
#(
  parameter int WID  = 16,
  parameter int SELW = 16,
  parameter int NCH  = 8,
  parameter int BLW  = 3,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  mpmc10_state_t              state,
  input  logic [CHW-1:0]             ch,
  input  logic [NCH-1:0]             we,
  input  logic [NCH-1:0][SELW-1:0]   sel,
  input  logic [NCH-1:0][31:0]       adr,
  input  logic [NCH-1:0][BLW-1:0]    blen,
  input  logic                       beat_rdy,
  output logic [WID-1:0]             mask,
  output logic                       mask_vld,
  output logic                       last,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = $clog2(WID);

  mpmc10_wmask_state_t fsm;
  logic [BLW-1:0]      cnt;
  logic [BLW-1:0]      cnt_nxt;
  logic [BLW-1:0]      blen_q;
  logic [WID-1:0]      placed_mask;

  mpmc10_lane_place #(
    .WID  (WID),
    .SELW (SELW)
  ) u_lane_place (
    .we       (we[ch]),
    .sel      (sel[ch]),
    .lane_adr (adr[ch][LW-1:0]),
    .mask     (placed_mask)
  );

  assign cnt_nxt = cnt + BLW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= S_IDLE;
      mask     <= '0;
      mask_vld <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      blen_q   <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (state == PRESET1) begin
            fsm      <= S_BEAT;
            mask     <= placed_mask;
            mask_vld <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            blen_q   <= blen[ch];
            last     <= (blen[ch] == '0);
          end
        end
        S_BEAT: begin
          // Abort wins over a coincident transfer; no done pulse on abort.
          if (state == IDLE) begin
            fsm      <= S_IDLE;
            mask     <= '0;
            mask_vld <= 1'b0;
            last     <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
          end else if (beat_rdy) begin
            if (last) begin
              fsm      <= S_DONE;
              mask     <= '0;
              mask_vld <= 1'b0;
              last     <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt  <= cnt_nxt;
              last <= (cnt_nxt == blen_q);
            end
          end
        end
        S_DONE: fsm <= S_IDLE;
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpmc10_wmask_sequencer.sv
// Scoreboarded bench for the write-mask sequencer: driver queues expected beats, a negedge monitor checks them.
module tb_mpmc10_wmask_sequencer;
  import mpmc10_pkg::*;

  localparam int WID = 16, SELW = 4, NCH = 8, BLW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mpmc10_state_t state = IDLE;
  logic [2:0] ch = '0;
  logic [NCH-1:0] we = '0;
  logic [NCH-1:0][SELW-1:0] sel = '0;
  logic [NCH-1:0][31:0] adr = '0;
  logic [NCH-1:0][BLW-1:0] blen = '0;
  logic beat_rdy = 1'b0;
  logic [WID-1:0] mask;
  logic mask_vld, last, busy, done;

  mpmc10_wmask_sequencer #(.WID(WID), .SELW(SELW), .NCH(NCH), .BLW(BLW)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .ch(ch), .we(we), .sel(sel), .adr(adr),
    .blen(blen), .beat_rdy(beat_rdy), .mask(mask), .mask_vld(mask_vld), .last(last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [WID-1:0] mask; logic last; } beat_t;
  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;
  bit done_due = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte b is written iff it falls inside the client's lane group and its select bit is set.
  function automatic logic [WID-1:0] ref_mask(input bit w, input logic [SELW-1:0] s, input logic [31:0] a);
    int off;
    logic [WID-1:0] m;
    off = (int'(a % WID) / SELW) * SELW;
    m = '1;
    if (!w) return '0;
    for (int b = 0; b < SELW; b++) if (s[b]) m[off + b] = 1'b0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      done_due = 0;
    end else begin
      if (done_due || done) begin
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("vld_at_done", mask_vld, 0);
        done_due = 0;
      end
      if (mask_vld) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          chk("beat_mask", mask, exp_q[0].mask);
          chk("beat_last", last, exp_q[0].last);
          if (beat_rdy) begin
            if (exp_q[0].last) done_due = 1;
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end
    end
  end

  task automatic scramble_inputs();
    for (int i = 0; i < NCH; i++) begin
      sel[i]  = SELW'($urandom);
      adr[i]  = $urandom;
      we[i]   = 1'($urandom);
      blen[i] = BLW'($urandom);
    end
  endtask

  task automatic start_burst(input int c, input bit w, input logic [SELW-1:0] s,
                             input logic [31:0] a, input int bl);
    logic [WID-1:0] m;
    scramble_inputs();
    ch = 3'(c);
    we[c] = w; sel[c] = s; adr[c] = a; blen[c] = BLW'(bl);
    state = PRESET1;
    m = ref_mask(w, s, a);
    for (int i = 0; i <= bl; i++) exp_q.push_back('{mask: m, last: (i == bl)});
    @(posedge clk); #1;
    state = WRITE_DATA;
    chk("vld_after_load", mask_vld, 1);
    chk("busy_after_load", busy, 1);
    scramble_inputs();
  endtask

  // mode 0: ready always; 1: fixed stall pattern then ready; 2: random ready.
  task automatic run_rdy(input int mode, output int cycles);
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      case (mode)
        0: beat_rdy = 1'b1;
        1: beat_rdy = (i < 7) ? pat[i] : 1'b1;
        default: beat_rdy = 1'($urandom);
      endcase
      @(posedge clk); #1;
      cycles++;
      if (!busy) break;
    end
    chk("burst_finished", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    beat_rdy = 1'b0;
    @(posedge clk); #1;
  endtask

  int cyc, x0;

  initial begin
    #22;
    chk("rst_mask", mask, 0);
    chk("rst_vld", mask_vld, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Narrow write: lanes 8..11, sel 0110 -> bytes 9,10 written.
    start_burst(3, 1'b1, 4'b0110, 32'h1234_5608, 0);
    chk("narrow_mask_const", mask, 16'hF9FF);
    chk("narrow_last", last, 1);
    run_rdy(0, cyc);
    chk("narrow_cycles", cyc, 1);

    // Read burst of 8.
    start_burst(5, 1'b0, 4'hF, 32'h0000_0004, 7);
    chk("read_mask_const", mask, 16'h0000);
    x0 = xfers;
    run_rdy(0, cyc);
    chk("read_cycles", cyc, 8);
    chk("read_xfers", xfers - x0, 8);

    // Stall pattern.
    start_burst(1, 1'b1, 4'b1011, 32'h0000_0003, 3);
    x0 = xfers;
    run_rdy(1, cyc);
    chk("stall_xfers", xfers - x0, 4);
    chk("stall_cycles", cyc, 7);

    // Abort after two beats.
    start_burst(6, 1'b1, 4'b0001, 32'h0000_000C, 3);
    x0 = xfers;
    beat_rdy = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    beat_rdy = 1'b0;
    state = IDLE;
    @(posedge clk); #1;
    exp_q.delete();
    chk("abort_xfers", xfers - x0, 2);
    chk("abort_vld", mask_vld, 0);
    chk("abort_busy", busy, 0);
    chk("abort_last", last, 0);
    chk("abort_mask", mask, 0);
    @(posedge clk); #1;
    chk("abort_no_done", done, 0);

    // PRESET1 during busy with another channel is ignored.
    start_burst(2, 1'b1, 4'b1100, 32'h0000_0004, 3);
    x0 = xfers;
    beat_rdy = 1'b1;
    @(posedge clk); #1;
    ch = 3'd5; we[5] = 1'b1; sel[5] = 4'b0001; adr[5] = 32'h0; blen[5] = 3'd7;
    state = PRESET1;
    @(posedge clk); #1;
    state = WRITE_DATA;
    run_rdy(0, cyc);
    chk("reload_ignored_xfers", xfers - x0, 4);

    // Reset during beat 2 of 4.
    start_burst(4, 1'b1, 4'b0101, 32'h0000_0008, 3);
    beat_rdy = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_mask", mask, 0);
    chk("midrst_vld", mask_vld, 0);
    chk("midrst_last", last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    beat_rdy = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_burst(0, 1'b1, 4'b1111, 32'h0000_0000, 1);
    chk("postrst_mask_const", mask, 16'hFFF0);
    run_rdy(0, cyc);
    chk("postrst_cycles", cyc, 2);

    // Randomized bursts.
    for (int n = 0; n < 25; n++) begin
      start_burst($urandom_range(0, NCH - 1), 1'($urandom), SELW'($urandom), $urandom,
                  $urandom_range(0, (1 << BLW) - 1));
      run_rdy(2, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
